uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_DIV, default 326, system clocks per oversample tick (50 MHz / (9600*16)); legal range >= 2.
REQ-002 Parameter OVERSAMPLE, default 16, ticks per bit; legal values are even and >= 8.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 rx  input  1  asynchronous serial line; idle-high.
REQ-009 data  output  DATA_BITS  received word, LSB first on the line; held stable while data_valid=1.
REQ-010 data_valid  output  1  word available; held high until accepted.
REQ-011 data_ready  input  1  consumer accepts the word on the cycle data_valid & data_ready.
REQ-012 frame_err  output  1  one-cycle pulse: a stop bit was sampled low.
REQ-013 parity_err  output  1  one-cycle pulse: parity mismatch (PARITY != 0 only).
REQ-014 overrun  output  1  one-cycle pulse: a good frame was dropped because data_valid was still high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 rx shall pass through a 2-flop synchroniser (reset value 1) before any use; the synchroniser adds 2 cycles of latency.
REQ-017 The tick counter shall count 0..CLK_DIV-1, emit a one-cycle tick at CLK_DIV-1, and restart from 0 on entry to START.
REQ-018 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 IDLE -> START on synchronised rx = 0; sample and bit counters are cleared.
REQ-020 Each bit shall be decided by majority vote of the synchronised rx on ticks M-1, M, M+1 of that bit, where M = OVERSAMPLE/2-1.
REQ-021 START: a start-bit vote of 1 (glitch) returns to IDLE with no output; otherwise the FSM moves to DATA after OVERSAMPLE ticks.
REQ-022 DATA: bit k is written to shift position k (LSB first); after DATA_BITS bits the FSM moves to PARITY if PARITY != 0, otherwise to STOP.
REQ-023 PARITY: the voted bit is compared with XOR(data) for even parity or ~XOR(data) for odd parity; the result is held until the frame ends.
REQ-024 STOP: each stop bit is voted; on a 0 vote, frame_err pulses and the FSM enters BREAK; after the last stop-bit vote (tick M+1), the FSM returns to IDLE without waiting out the bit.
REQ-025 BREAK: remain until synchronised rx = 1, then go to IDLE.
REQ-026 Frame completion occurs on the cycle after the last stop-bit vote. A good frame with data_valid=0 loads data and sets data_valid. A good frame with data_valid=1 and data_ready=0 is dropped, data is unchanged, and overrun pulses.
REQ-027 A parity-error frame shall pulse parity_err and shall not be delivered; frame_err takes priority if both errors occur.
REQ-028 Acceptance and completion on the same cycle: the new word loads, data_valid stays 1, and there is no overrun.
REQ-029 Counters shall wrap only through explicit clears; there is no modulo overflow in any state.

Reset
REQ-030 When rst=1, the state is IDLE, all counters are 0, the synchroniser is 1, data=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, and busy=0.
REQ-031 Reset asserted mid-frame shall abort the frame with no output pulses; reception restarts on the next falling edge after release.

Structure
REQ-032 The shared package uart_pkg shall hold the state enum, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and the default CLK_DIV/OVERSAMPLE values.
REQ-033 The tick generator shall be the sub-module uart_baud_tick (CLK_DIV parameter, clear input, tick output), reusable by the transmitter.

Verification (CLK_DIV=4, OVERSAMPLE=16: bit period 64 clk)
REQ-034 Default 8N1, send 0xA5 -> data=0xA5 and data_valid=1 about 9.5 bit periods after the start edge; held until data_ready.
REQ-035 PARITY=2, send 0x3C with parity bit 1 -> parity_err pulses once, data_valid stays 0; with parity bit 0 -> data=0x3C delivered.
REQ-036 Stop bit driven low, then rx held low 200 clk -> frame_err pulses once, busy=1 until rx high, no second frame detected.
REQ-037 20-clk low glitch on an idle line -> returns to IDLE, no outputs; 1-clk glitch at mid-data bit -> majority vote masks it, correct byte.
REQ-038 Two frames 0x11, 0x22 with data_ready=0 -> data=0x11, overrun pulses at second completion; data_ready pulsed on the completion cycle -> 0x22 loads, no overrun.
REQ-039 DATA_BITS=5, STOP_BITS=2, send 0x1F; rst pulsed mid-DATA -> no output, then next frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, parity modes, default timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock, 9600 baud, 16x oversampling
    localparam int DEF_CLK_DIV    = 326;
    localparam int DEF_OVERSAMPLE = 16;

    // 2-of-3 majority used to decide each bit
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-to-consumer word handshake plus status pulses.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data, data_valid, frame_err, parity_err, overrun, busy,
        input  data_ready
    );

    modport slave (
        input  data, data_valid, frame_err, parity_err, overrun, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, restartable.
module uart_baud_tick import uart_pkg::*; #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // count 0..CLK_DIV-1; clear realigns the phase to the caller's event
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST) cnt_d = '0;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit decisions,
// optional parity, 1 or 2 stop bits, valid/ready word delivery.
module uart_rx_cfg import uart_pkg::*; #(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_cfg_if.master bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    // votes land on ticks M-1, M, M+1 with M = OVERSAMPLE/2-1
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 2);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] P_LAST = BW'(STOP_BITS - 1);

    logic [1:0]           sync_q, sync_d;
    state_e               state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_bad_q, par_bad_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s, tick, baud_clr, voted, mid, end_bit, par_exp;

    assign rx_s = sync_q[1];

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clr),
        .tick  (tick)
    );

    // two-flop synchroniser on the asynchronous line
    always_comb sync_d = {sync_q[0], rx};

    // frame FSM: bit timing, voting, shift register and stop/parity checks
    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        b_cnt_d     = b_cnt_q;
        vote_d      = vote_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        baud_clr    = 1'b0;
        voted       = maj3(vote_q[0], vote_q[1], rx_s);
        mid         = tick && (s_cnt_q == S_V2);
        end_bit     = tick && (s_cnt_q == S_LAST);
        par_exp     = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

        if (state_q != ST_IDLE && state_q != ST_BREAK && tick) begin
            s_cnt_d = end_bit ? '0 : s_cnt_q + 1'b1;
            if (s_cnt_q == S_V0) vote_d[0] = rx_s;
            if (s_cnt_q == S_V1) vote_d[1] = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    s_cnt_d   = '0;
                    b_cnt_d   = '0;
                    par_bad_d = 1'b0;
                    baud_clr  = 1'b1;
                end
            end
            ST_START: begin
                if (mid && voted) state_d = ST_IDLE;   // glitch, not a start bit
                else if (end_bit) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (mid) begin
                    for (int k = 0; k < DATA_BITS; k++)
                        if (b_cnt_q == BW'(k)) shift_d[k] = voted;
                end
                if (end_bit) begin
                    if (b_cnt_q == D_LAST) begin
                        b_cnt_d = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        b_cnt_d = b_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (mid) par_bad_d = (voted != par_exp);
                if (end_bit) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (mid) begin
                    if (!voted) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else if (b_cnt_q == P_LAST) begin
                        // last stop bit good: finish now, don't wait out the bit
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (end_bit) begin
                    b_cnt_d = b_cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // delivery: consumer handshake, new-word load, parity drop and overrun
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;
        if (valid_q && bus.data_ready) valid_d = 1'b0;
        if (done_q) begin
            if (par_bad_q) begin
                parity_err_d = 1'b1;
            end else if (!valid_q || bus.data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= ST_IDLE;
            s_cnt_q      <= '0;
            b_cnt_q      <= '0;
            vote_q       <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            par_bad_q    <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            b_cnt_q      <= b_cnt_d;
            vote_q       <= vote_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            par_bad_q    <= par_bad_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 5N2) at 64 clk/bit.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rx_a, rx_p, rx_b;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   fe_c[3], pe_c[3], ov_c[3];
    int   rise_a = 0;
    logic prev_va = 1'b0;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_p ();
    uart_rx_cfg_if #(.DATA_BITS(5)) if_b ();

    uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst(rst), .rx(rx_a), .bus(if_a));
    uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_p (.clk(clk), .rst(rst), .rx(rx_p), .bus(if_p));
    uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2))
        dut_b (.clk(clk), .rst(rst), .rx(rx_b), .bus(if_b));

    always @(posedge clk) cyc <= cyc + 1;

    // pulse counters and valid-rise timestamp, sampled mid-cycle
    always @(negedge clk) begin
        if (if_a.frame_err)  fe_c[0] <= fe_c[0] + 1;
        if (if_p.frame_err)  fe_c[1] <= fe_c[1] + 1;
        if (if_b.frame_err)  fe_c[2] <= fe_c[2] + 1;
        if (if_a.parity_err) pe_c[0] <= pe_c[0] + 1;
        if (if_p.parity_err) pe_c[1] <= pe_c[1] + 1;
        if (if_b.parity_err) pe_c[2] <= pe_c[2] + 1;
        if (if_a.overrun)    ov_c[0] <= ov_c[0] + 1;
        if (if_p.overrun)    ov_c[1] <= ov_c[1] + 1;
        if (if_b.overrun)    ov_c[2] <= ov_c[2] + 1;
        prev_va <= if_a.data_valid;
        if (if_a.data_valid && !prev_va) rise_a <= cyc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // outcome of a frame: 0 = good word, 1 = parity error, 2 = framing error
    function automatic int ref_outcome(input int nb, input int v, input int pmode,
                                       input logic pbit, input logic [1:0] stops, input int nstop);
        int ones;
        ones = 0;
        for (int i = 0; i < nstop; i++) if (stops[i] == 1'b0) return 2;
        if (pmode == 0) return 0;
        for (int i = 0; i < nb; i++) ones += (v >> i) & 1;
        ones += int'(pbit);
        if (pmode == 2) return (ones % 2 == 0) ? 0 : 1;
        return (ones % 2 == 1) ? 0 : 1;
    endfunction

    function automatic logic [15:0] mk_frame(input int nb, input int v, input bit has_par,
                                             input logic pbit, input logic [1:0] stops, input int nstop);
        logic [15:0] f;
        int p;
        f = '1;
        f[0] = 1'b0;
        p = 1;
        for (int i = 0; i < nb; i++) begin f[p] = 1'((v >> i) & 1); p++; end
        if (has_par) begin f[p] = pbit; p++; end
        for (int i = 0; i < nstop; i++) begin f[p] = stops[i]; p++; end
        return f;
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic get_valid(input int d);
        case (d)
            0:       return if_a.data_valid;
            1:       return if_p.data_valid;
            default: return if_b.data_valid;
        endcase
    endfunction

    function automatic logic [7:0] get_data(input int d);
        case (d)
            0:       return if_a.data;
            1:       return if_p.data;
            default: return {3'b000, if_b.data};
        endcase
    endfunction

    function automatic logic [4:0] get_flags(input int d);
        case (d)
            0:       return {if_a.data_valid, if_a.frame_err, if_a.parity_err, if_a.overrun, if_a.busy};
            1:       return {if_p.data_valid, if_p.frame_err, if_p.parity_err, if_p.overrun, if_p.busy};
            default: return {if_b.data_valid, if_b.frame_err, if_b.parity_err, if_b.overrun, if_b.busy};
        endcase
    endfunction

    task automatic drive_rx(input int d, input logic v);
        case (d)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_b = v;
        endcase
    endtask

    task automatic set_ready(input int d, input logic v);
        case (d)
            0:       if_a.data_ready = v;
            1:       if_p.data_ready = v;
            default: if_b.data_ready = v;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic accept(input int d);
        @(negedge clk); set_ready(d, 1'b1);
        @(negedge clk); set_ready(d, 1'b0);
    endtask

    task automatic gap(input int d);
        @(negedge clk); drive_rx(d, 1'b1);
        idle(20);
    endtask

    task automatic wait_valid(input int d, input int lim);
        int w;
        w = 0;
        while (!get_valid(d) && w < lim) begin @(negedge clk); w++; end
    endtask

    // drives a whole frame, 64 clk per bit; optional inverted window [g_at, g_at+g_len)
    task automatic send_frame(input int d, input int nb, input int v, input bit has_par,
                              input logic pbit, input logic [1:0] stops, input int nstop,
                              input int g_at, input int g_len);
        logic [15:0] f;
        int n;
        f = mk_frame(nb, v, has_par, pbit, stops, nstop);
        n = 1 + nb + int'(has_par) + nstop;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 64; c++) begin
                int t;
                logic b;
                t = i * 64 + c;
                b = f[i];
                if (t >= g_at && t < g_at + g_len) b = ~b;
                @(negedge clk);
                drive_rx(d, b);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1;
        if_a.data_ready = 1'b0; if_p.data_ready = 1'b0; if_b.data_ready = 1'b0;
        idle(5);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (get_flags(d) !== 5'b0) begin
                fails++; $display("FAIL reset_flags dut%0d: got %b want 00000", d, get_flags(d));
            end
            tests++;
            if (get_data(d) !== 8'h00) begin
                fails++; $display("FAIL reset_data dut%0d: got %h want 00", d, get_data(d));
            end
        end
        @(negedge clk); rst = 1'b0;
        idle(10);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (get_flags(d) !== 5'b0) begin
                fails++; $display("FAIL post_reset_idle dut%0d: got %b want 00000", d, get_flags(d));
            end
        end
    endtask

    task automatic test_basic_8n1;
        int t0, ov0, fe0, lat;
        logic [7:0] v;
        ov0 = ov_c[0]; fe0 = fe_c[0];
        t0 = cyc;
        send_frame(0, 8, 'hA5, 1'b0, 1'b0, 2'b11, 1, -1, 0);
        wait_valid(0, 200);
        tests++;
        if (if_a.data_valid !== 1'b1 || if_a.data !== 8'hA5) begin
            fails++; $display("FAIL basic_a5: valid=%b data=%h want 1/a5", if_a.data_valid, if_a.data);
        end
        lat = rise_a - t0;
        tests++;
        if (lat < 9 * 64 + 16 || lat > 10 * 64) begin
            fails++; $display("FAIL basic_latency: got %0d clk want 592..640", lat);
        end
        gap(0);
        idle(40);
        tests++;
        if (if_a.data_valid !== 1'b1 || if_a.data !== 8'hA5) begin
            fails++; $display("FAIL basic_hold: valid=%b data=%h want 1/a5", if_a.data_valid, if_a.data);
        end
        accept(0);
        @(negedge clk);
        tests++;
        if (if_a.data_valid !== 1'b0) begin
            fails++; $display("FAIL basic_accept: valid=%b want 0", if_a.data_valid);
        end
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom_range(0, 255));
            send_frame(0, 8, int'(v), 1'b0, 1'b0, 2'b11, 1, -1, 0);
            wait_valid(0, 200);
            tests++;
            if (if_a.data_valid !== 1'b1 || if_a.data !== v) begin
                fails++; $display("FAIL basic_rand: valid=%b data=%h want 1/%h", if_a.data_valid, if_a.data, v);
            end
            accept(0);
            gap(0);
        end
        tests++;
        if (ov_c[0] - ov0 != 0 || fe_c[0] - fe0 != 0) begin
            fails++; $display("FAIL basic_no_err: overrun=%0d frame_err=%0d want 0/0", ov_c[0] - ov0, fe_c[0] - fe0);
        end
    endtask

    task automatic test_parity;
        int pe0, oc;
        logic [7:0] v;
        logic pb;
        pe0 = pe_c[1];
        send_frame(1, 8, 'h3C, 1'b1, 1'b1, 2'b11, 1, -1, 0);
        gap(1);
        tests++;
        if (pe_c[1] - pe0 != 1 || if_p.data_valid !== 1'b0) begin
            fails++; $display("FAIL parity_bad_3c: pulses=%0d valid=%b want 1/0", pe_c[1] - pe0, if_p.data_valid);
        end
        pe0 = pe_c[1];
        send_frame(1, 8, 'h3C, 1'b1, 1'b0, 2'b11, 1, -1, 0);
        wait_valid(1, 200);
        tests++;
        if (if_p.data_valid !== 1'b1 || if_p.data !== 8'h3C || pe_c[1] != pe0) begin
            fails++; $display("FAIL parity_good_3c: valid=%b data=%h perr=%0d want 1/3c/0",
                              if_p.data_valid, if_p.data, pe_c[1] - pe0);
        end
        accept(1);
        gap(1);
        for (int i = 0; i < 6; i++) begin
            v  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            oc = ref_outcome(8, int'(v), 2, pb, 2'b11, 1);
            pe0 = pe_c[1];
            send_frame(1, 8, int'(v), 1'b1, pb, 2'b11, 1, -1, 0);
            gap(1);
            tests++;
            if (if_p.data_valid !== (oc == 0) || pe_c[1] - pe0 != int'(oc == 1)) begin
                fails++; $display("FAIL parity_rand v=%h p=%b: valid=%b perr=%0d want %b/%0d",
                                  v, pb, if_p.data_valid, pe_c[1] - pe0, oc == 0, int'(oc == 1));
            end
            if (oc == 0) begin
                tests++;
                if (if_p.data !== v) begin
                    fails++; $display("FAIL parity_rand_data: got %h want %h", if_p.data, v);
                end
                accept(1);
            end
        end
    endtask

    task automatic test_frame_err;
        int fe0, low_busy;
        fe0 = fe_c[0];
        send_frame(0, 8, 'h5A, 1'b0, 1'b0, 2'b10, 1, -1, 0);
        low_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_a.busy !== 1'b1) low_busy++;
        end
        tests++;
        if (low_busy != 0) begin
            fails++; $display("FAIL break_busy: busy low for %0d cycles want 0", low_busy);
        end
        tests++;
        if (fe_c[0] - fe0 != 1) begin
            fails++; $display("FAIL frame_err_count: got %0d want 1", fe_c[0] - fe0);
        end
        gap(0);
        tests++;
        if (if_a.busy !== 1'b0 || if_a.data_valid !== 1'b0 || fe_c[0] - fe0 != 1) begin
            fails++; $display("FAIL break_exit: busy=%b valid=%b ferr=%0d want 0/0/1",
                              if_a.busy, if_a.data_valid, fe_c[0] - fe0);
        end
    endtask

    task automatic test_glitch;
        int fe0, pe0, ov0, bi, off;
        logic [7:0] v;
        fe0 = fe_c[0]; pe0 = pe_c[0]; ov0 = ov_c[0];
        @(negedge clk); rx_a = 1'b0;
        idle(20);
        rx_a = 1'b1;
        idle(100);
        tests++;
        if (if_a.busy !== 1'b0 || if_a.data_valid !== 1'b0 ||
            fe_c[0] != fe0 || pe_c[0] != pe0 || ov_c[0] != ov0) begin
            fails++; $display("FAIL idle_glitch: busy=%b valid=%b errs=%0d/%0d/%0d want all 0",
                              if_a.busy, if_a.data_valid, fe_c[0] - fe0, pe_c[0] - pe0, ov_c[0] - ov0);
        end
        for (int i = 0; i < 3; i++) begin
            v   = 8'($urandom_range(0, 255));
            bi  = $urandom_range(1, 8);
            off = $urandom_range(26, 42);
            send_frame(0, 8, int'(v), 1'b0, 1'b0, 2'b11, 1, bi * 64 + off, 1);
            wait_valid(0, 200);
            tests++;
            if (if_a.data_valid !== 1'b1 || if_a.data !== v) begin
                fails++; $display("FAIL mid_glitch bit%0d off%0d: valid=%b data=%h want 1/%h",
                                  bi, off, if_a.data_valid, if_a.data, v);
            end
            accept(0);
            gap(0);
        end
    endtask

    task automatic test_back_to_back;
        int ov0, w;
        bit seen, to;
        ov0 = ov_c[0];
        send_frame(0, 8, 'h11, 1'b0, 1'b0, 2'b11, 1, -1, 0);
        send_frame(0, 8, 'h22, 1'b0, 1'b0, 2'b11, 1, -1, 0);
        gap(0);
        tests++;
        if (if_a.data_valid !== 1'b1 || if_a.data !== 8'h11 || ov_c[0] - ov0 != 1) begin
            fails++; $display("FAIL overrun: valid=%b data=%h ovr=%0d want 1/11/1",
                              if_a.data_valid, if_a.data, ov_c[0] - ov0);
        end
        accept(0);
        gap(0);
        ov0 = ov_c[0];
        send_frame(0, 8, 'h11, 1'b0, 1'b0, 2'b11, 1, -1, 0);
        seen = 1'b0; to = 1'b0;
        fork
            send_frame(0, 8, 'h22, 1'b0, 1'b0, 2'b11, 1, -1, 0);
            begin
                w = 0;
                while (!if_a.busy && w < 300) begin @(negedge clk); w++; end
                seen = if_a.busy;
                while (if_a.busy && w < 2000) begin @(negedge clk); w++; end
                to = !seen || if_a.busy;
                // busy just dropped: this is the completion cycle
                set_ready(0, 1'b1);
                @(negedge clk);
                set_ready(0, 1'b0);
            end
        join
        gap(0);
        tests++;
        if (to !== 1'b0) begin
            fails++; $display("FAIL b2b_timeout: busy edge not observed (%b) want 0", to);
        end
        tests++;
        if (if_a.data_valid !== 1'b1 || if_a.data !== 8'h22 || ov_c[0] != ov0) begin
            fails++; $display("FAIL same_cycle_accept: valid=%b data=%h ovr=%0d want 1/22/0",
                              if_a.data_valid, if_a.data, ov_c[0] - ov0);
        end
        accept(0);
        gap(0);
    endtask

    task automatic test_reset_mid;
        int fe0, oc;
        logic [4:0] v;
        logic [1:0] st;
        fe0 = fe_c[2];
        @(negedge clk); rx_b = 1'b0;
        idle(64);
        rx_b = 1'b1;
        idle(96);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (get_flags(2) !== 5'b0) begin
            fails++; $display("FAIL reset_mid_abort: flags=%b want 00000", get_flags(2));
        end
        idle(400);
        tests++;
        if (get_flags(2) !== 5'b0 || fe_c[2] != fe0) begin
            fails++; $display("FAIL reset_mid_quiet: flags=%b ferr=%0d want 00000/0", get_flags(2), fe_c[2] - fe0);
        end
        send_frame(2, 5, 'h1F, 1'b0, 1'b0, 2'b11, 2, -1, 0);
        wait_valid(2, 200);
        tests++;
        if (if_b.data_valid !== 1'b1 || if_b.data !== 5'h1F) begin
            fails++; $display("FAIL b5_1f: valid=%b data=%h want 1/1f", if_b.data_valid, if_b.data);
        end
        accept(2);
        gap(2);
        for (int i = 0; i < 4; i++) begin
            v  = 5'($urandom_range(0, 31));
            st = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b11;
            oc = ref_outcome(5, int'(v), 0, 1'b0, st, 2);
            fe0 = fe_c[2];
            send_frame(2, 5, int'(v), 1'b0, 1'b0, st, 2, -1, 0);
            gap(2);
            tests++;
            if (if_b.data_valid !== (oc == 0) || fe_c[2] - fe0 != int'(oc == 2)) begin
                fails++; $display("FAIL b5_rand v=%h st=%b: valid=%b ferr=%0d want %b/%0d",
                                  v, st, if_b.data_valid, fe_c[2] - fe0, oc == 0, int'(oc == 2));
            end
            if (oc == 0) begin
                tests++;
                if (if_b.data !== v) begin
                    fails++; $display("FAIL b5_rand_data: got %h want %h", if_b.data, v);
                end
                accept(2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
